// File: rtl/seven_seg_scroll_ascii.sv
// Multiplexed ASCII driver for common-anode seven-segment banks.
// Presents a runtime message buffer as static, scroll-left, scroll-right or blinking text.
module seven_seg_scroll_ascii #(
  parameter int DISPLAY_COUNT = 8,
  parameter int MSG_LEN       = 16,
  parameter int REFRESH_DIV   = 100000,
  parameter int STEP_DIV      = 25000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [8*MSG_LEN-1:0]         message,
  input  logic [$clog2(MSG_LEN+1)-1:0] msg_len,
  input  logic [1:0]                   mode,
  input  logic                         restart,
  output logic [6:0]                   segments,
  output logic [DISPLAY_COUNT-1:0]     enable,
  output logic                         wrap
);
  localparam int LW  = $clog2(MSG_LEN + 1);
  localparam int PW  = $clog2(MSG_LEN + DISPLAY_COUNT + 1);
  localparam int PW1 = PW + 1;
  localparam int IW  = (DISPLAY_COUNT > 1) ? $clog2(DISPLAY_COUNT) : 1;
  localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

  logic [IW-1:0]  scan_idx;
  logic [RW-1:0]  refresh_cnt;
  logic [SW-1:0]  step_cnt;
  logic [PW-1:0]  offset;
  logic           blank_phase;
  mode_t          mode_q;

  logic [LW-1:0]  len_c;
  logic [PW-1:0]  period;
  logic           refresh_tc;
  logic           step_tc;
  logic           resync;
  logic [PW1-1:0] pos_sum;
  logic [PW-1:0]  pos;
  logic [7:0]     ch;
  logic [6:0]     glyph;
  logic [PW-1:0]  offset_n;
  logic [SW-1:0]  step_n;
  logic           blank_n;
  logic           wrap_n;

  // Active-low glyphs, bit0=a .. bit6=g; lowercase folds onto the uppercase set.
  function automatic logic [6:0] font(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    case (u)
      "0": return 7'h40;
      "1": return 7'h79;
      "2": return 7'h24;
      "3": return 7'h30;
      "4": return 7'h19;
      "5": return 7'h12;
      "6": return 7'h02;
      "7": return 7'h78;
      "8": return 7'h00;
      "9": return 7'h10;
      "A": return 7'h08;
      "B": return 7'h03;
      "C": return 7'h46;
      "D": return 7'h21;
      "E": return 7'h06;
      "F": return 7'h0E;
      "G": return 7'h42;
      "H": return 7'h09;
      "I": return 7'h79;
      "J": return 7'h61;
      "K": return 7'h09;
      "L": return 7'h47;
      "N": return 7'h2B;
      "O": return 7'h23;
      "P": return 7'h0C;
      "Q": return 7'h18;
      "R": return 7'h2F;
      "S": return 7'h12;
      "T": return 7'h07;
      "U": return 7'h41;
      "X": return 7'h09;
      "Y": return 7'h11;
      "-": return 7'h3F;
      "_": return 7'h77;
      default: return 7'h7F;
    endcase
  endfunction

  // Window lookup: the digit under scan shows virtual position (offset + DC-1-idx) mod P.
  always_comb begin
    len_c      = (msg_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len;
    period     = PW'(len_c) + PW'(DISPLAY_COUNT);
    refresh_tc = (refresh_cnt == RW'(REFRESH_DIV - 1));
    step_tc    = (step_cnt == SW'(STEP_DIV - 1));
    resync     = restart || (mode_t'(mode) != mode_q);
    pos_sum    = {1'b0, offset} + PW1'(DISPLAY_COUNT - 1) - PW1'(scan_idx);
    pos        = (pos_sum >= {1'b0, period}) ? PW'(pos_sum - {1'b0, period}) : PW'(pos_sum);
    ch         = 8'h20;
    if (pos < PW'(len_c)) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (pos == PW'(i)) ch = message[8*(MSG_LEN-1-i) +: 8];
      end
    end
    glyph = font(ch);
  end

  // Offset, step timer and blink phase; resync beats a coincident tick.
  always_comb begin
    offset_n = offset;
    blank_n  = 1'b0;
    wrap_n   = 1'b0;
    step_n   = step_tc ? '0 : step_cnt + 1'b1;
    if (resync) begin
      offset_n = '0;
      step_n   = '0;
    end else begin
      case (mode_q)
        MODE_LEFT: begin
          if (len_c == '0 || offset >= period) begin
            offset_n = '0;
          end else if (step_tc) begin
            if (offset == period - 1'b1) begin
              offset_n = '0;
              wrap_n   = 1'b1;
            end else begin
              offset_n = offset + 1'b1;
            end
          end
        end
        MODE_RIGHT: begin
          if (len_c == '0 || offset >= period) begin
            offset_n = '0;
          end else if (step_tc) begin
            if (offset == '0) begin
              offset_n = period - 1'b1;
              wrap_n   = 1'b1;
            end else begin
              offset_n = offset - 1'b1;
            end
          end
        end
        MODE_BLINK: begin
          offset_n = '0;
          blank_n  = step_tc ? ~blank_phase : blank_phase;
        end
        default: offset_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx    <= '0;
      refresh_cnt <= '0;
      step_cnt    <= '0;
      offset      <= '0;
      blank_phase <= 1'b0;
      mode_q      <= mode_t'(mode);
      segments    <= 7'h7F;
      enable      <= '1;
      wrap        <= 1'b0;
    end else begin
      refresh_cnt <= refresh_tc ? '0 : refresh_cnt + 1'b1;
      if (refresh_tc)
        scan_idx <= (scan_idx == IW'(DISPLAY_COUNT - 1)) ? '0 : scan_idx + 1'b1;
      step_cnt    <= step_n;
      offset      <= offset_n;
      blank_phase <= blank_n;
      mode_q      <= mode_t'(mode);
      wrap        <= wrap_n;
      enable      <= ~(DISPLAY_COUNT'(1) << scan_idx);
      segments    <= blank_phase ? 7'h7F : glyph;
    end
  end
endmodule

// File: tb/tb_seven_seg_scroll_ascii.sv
// Directed bench for seven_seg_scroll_ascii: 4 digits, 8-char buffer, fast refresh and step.
module tb_seven_seg_scroll_ascii;
  localparam int DC = 4;
  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] message;
  logic [3:0]  msg_len;
  logic [1:0]  mode;
  logic        restart;
  logic [6:0]  segments;
  logic [3:0]  enable;
  logic        wrap;

  int checks = 0;
  int failures = 0;
  int edge_k = 0;
  int wrap_count = 0;
  int lit_count = 0;

  logic [3:0] scan_exp [9] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};
  logic [6:0] left_exp [7] = '{7'h09, 7'h47, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h09};
  logic [6:0] right_exp [7] = '{7'h09, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h47, 7'h09};

  always #5 clk = ~clk;

  seven_seg_scroll_ascii #(
    .DISPLAY_COUNT(DC),
    .MSG_LEN(ML),
    .REFRESH_DIV(2),
    .STEP_DIV(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .message(message),
    .msg_len(msg_len),
    .mode(mode),
    .restart(restart),
    .segments(segments),
    .enable(enable),
    .wrap(wrap)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Holds reset for three cycles with the new inputs, then counts edges from release.
  task automatic applyStimulus(input logic [63:0] msg, input logic [3:0] len, input logic [1:0] md);
    @(negedge clk);
    reset   = 1'b1;
    restart = 1'b0;
    message = msg;
    msg_len = len;
    mode    = md;
    repeat (3) @(negedge clk);
    checkOutput("reset_enable", 32'(enable), 32'h F);
    checkOutput("reset_segments", 32'(segments), 32'h7F);
    checkOutput("reset_wrap", 32'(wrap), 32'h0);
    reset      = 1'b0;
    edge_k     = 0;
    wrap_count = 0;
  endtask

  task automatic runTo(input int k);
    while (edge_k < k) begin
      @(negedge clk);
      edge_k++;
      if (wrap === 1'b1) wrap_count++;
    end
  endtask

  task automatic checkDigit(input string tag, input int k, input int d, input logic [6:0] exp_seg);
    logic [3:0] en_exp;
    runTo(k);
    en_exp = ~(4'b0001 << d);
    checkOutput({tag, "_en"}, 32'(enable), 32'(en_exp));
    checkOutput(tag, 32'(segments), 32'(exp_seg));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b1;
    restart = 1'b0;
    message = '0;
    msg_len = '0;
    mode    = 2'b00;

    $display("[TB] scan order and static HL");
    applyStimulus("HL012345", 4'd2, 2'b00);
    for (int k = 1; k <= 9; k++) begin
      runTo(k);
      checkOutput($sformatf("scan_en_%0d", k), 32'(enable), 32'(scan_exp[k-1]));
    end
    checkDigit("static_d0", 9, 0, 7'h7F);
    checkDigit("static_d1", 11, 1, 7'h7F);
    checkDigit("static_d2", 13, 2, 7'h47);
    checkDigit("static_d3", 15, 3, 7'h09);
    runTo(800);
    checkOutput("static_wrap_count", 32'(wrap_count), 32'd0);

    $display("[TB] scroll-left HL");
    applyStimulus("HL012345", 4'd2, 2'b01);
    for (int n = 0; n < 7; n++) begin
      checkDigit($sformatf("left_d3_%0d", n), 8*n + 7, 3, left_exp[n]);
      if (n == 5) begin
        checkOutput("left_wrap_pre", 32'(wrap), 32'd0);
        runTo(48);
        checkOutput("left_wrap_tick6", 32'(wrap), 32'd1);
      end
    end
    checkOutput("left_wrap_count", 32'(wrap_count), 32'd1);

    $display("[TB] scroll-right HL");
    applyStimulus("HL012345", 4'd2, 2'b10);
    checkDigit("right_d3_0", 7, 3, right_exp[0]);
    runTo(8);
    checkOutput("right_wrap_tick1", 32'(wrap), 32'd1);
    for (int n = 1; n < 7; n++)
      checkDigit($sformatf("right_d3_%0d", n), 8*n + 7, 3, right_exp[n]);
    checkOutput("right_wrap_count", 32'(wrap_count), 32'd1);

    $display("[TB] blink 0 and restart on tick");
    applyStimulus({"0", 56'h0}, 4'd1, 2'b11);
    checkDigit("blink_on_a", 7, 3, 7'h40);
    checkDigit("blink_on_b", 8, 3, 7'h40);
    for (int k = 9; k <= 16; k++) begin
      runTo(k);
      checkOutput($sformatf("blink_off_%0d", k), 32'(segments), 32'h7F);
    end
    checkDigit("blink_on_c", 23, 3, 7'h40);
    restart = 1'b1;
    runTo(24);
    restart = 1'b0;
    checkDigit("restart_d3_a", 31, 3, 7'h40);
    checkDigit("restart_d3_b", 32, 3, 7'h40);
    checkDigit("restart_d3_off", 39, 3, 7'h7F);

    $display("[TB] empty message in scroll mode");
    applyStimulus("HL012345", 4'd0, 2'b01);
    for (int k = 1; k <= 100; k++) begin
      runTo(k);
      if (segments !== 7'h7F) lit_count++;
    end
    checkOutput("empty_lit_count", 32'(lit_count), 32'd0);
    checkOutput("empty_wrap_count", 32'(wrap_count), 32'd0);

    $display("[TB] oversize length clamps to buffer");
    applyStimulus("HL012345", 4'd15, 2'b01);
    checkDigit("clamp_d3_pos7", 63, 3, 7'h12);
    checkDigit("clamp_d3_pos8", 71, 3, 7'h7F);
    runTo(95);
    checkOutput("clamp_wrap_pre", 32'(wrap_count), 32'd0);
    runTo(96);
    checkOutput("clamp_wrap_tick12", 32'(wrap), 32'd1);
    checkDigit("clamp_d3_pos0", 103, 3, 7'h09);

    $display("[TB] mode switch mid-scroll");
    applyStimulus("HL012345", 4'd8, 2'b01);
    runTo(30);
    mode = 2'b00;
    checkDigit("switch_d3_old", 31, 3, 7'h79);
    checkDigit("switch_d3_new", 32, 3, 7'h09);
    checkDigit("switch_d3_held", 71, 3, 7'h09);

    $display("[TB] length shrink below offset");
    applyStimulus("HL012345", 4'd8, 2'b01);
    runTo(48);
    msg_len = 4'd1;
    checkDigit("shrink_d3", 55, 3, 7'h09);
    checkOutput("shrink_wrap_count", 32'(wrap_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_seg_scroll_ascii.md
Name: seven_seg_scroll_ascii

Overview:
Parametrised multiplexed ASCII driver for common-anode seven-segment banks. Supersedes the fixed-string display driver: it takes a runtime message buffer of up to MSG_LEN characters and a runtime length, and shows it in one of four modes: static, scroll-left, scroll-right or blink. It sits between board-level top modules and the disp_seg/disp_an pins, and emits a wrap pulse so higher logic can sequence messages.

Parameters:
DISPLAY_COUNT, 8, number of physical digits (1..16)
MSG_LEN, 16, maximum message characters (>=1)
REFRESH_DIV, 100000, clock cycles each digit stays lit during the scan
STEP_DIV, 25000000, clock cycles per scroll step or blink half-period

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
message  in  8*MSG_LEN  ASCII buffer; char 0 = message[8*MSG_LEN-1 -: 8] (string-literal order)
msg_len  in  $clog2(MSG_LEN+1)  valid characters; values above MSG_LEN are clamped to MSG_LEN
mode  in  2  00 static, 01 scroll-left, 10 scroll-right, 11 blink
restart  in  1  single-cycle pulse; resets scroll offset and step timer
segments  out  7  active-low, bit0=a .. bit6=g
enable  out  DISPLAY_COUNT  active-low anode select, one-hot-low
wrap  out  1  one-cycle pulse when the scroll offset wraps

Behaviour:
- Reset: segments=7'h7F, enable=all ones, wrap=0, scan index=0, offset=0, refresh and step counters=0, blank_phase=0, registered mode copy=mode.
- Scan: the refresh counter counts 0..REFRESH_DIV-1. At terminal count the scan index advances 0→DISPLAY_COUNT-1→0. Index 0 is the rightmost digit.
- Outputs are registered: enable and segments reflect the scan index and window from the previous cycle. The first cycle after reset release drives enable=~1 (digit 0).
- Virtual sequence: P = L + DISPLAY_COUNT, where L = clamped msg_len. Position p < L gives char p; positions L..P-1 are blank.
- Window: digit d shows sequence position (offset + DISPLAY_COUNT-1-d) mod P. The leftmost digit shows position offset.
- Step tick: the step counter counts 0..STEP_DIV-1. A tick is issued at terminal count.
- static (00): offset held at 0. Chars beyond L are blank.
- scroll-left (01): each tick sets offset = offset+1. At offset P-1 it wraps to 0 and wrap=1 for one cycle.
- scroll-right (10): each tick sets offset = offset-1. At offset 0 it wraps to P-1 and wrap=1.
- blink (11): offset held at 0. Each tick toggles blank_phase. While blank_phase=1, segments=7'h7F and the scan continues.
- L=0: all digits blank, offset held at 0, wrap never asserted.
- Mode change, detected against the registered copy: on the next cycle offset=0, step counter=0, blank_phase=0, no wrap. The scan is unaffected.
- restart: same effect as a mode change. If restart coincides with a tick, restart wins, with no step and no wrap.
- msg_len changing mid-scroll: P is recomputed on the next cycle. If offset >= new P, offset is forced to 0 with no wrap.
- Font (combinational, active-low): '0'-'9'; 'A'-'Z' and 'a'-'z' map to a shared best-effort glyph set (A b C d E F G H I J K L n o P q r S t U y; unsupported letters such as M, W, X show H-style or blank per the font table); '-' lights g only; '_' lights d only; space and all other codes are blank (7'h7F). Example glyphs: '0'=7'h40, 'H'=7'h09, 'L'=7'h47.
- Only one anode is ever low. There is no all-low glitch on scan wrap.

Test Plan:
- Scan order (DISPLAY_COUNT=4, REFRESH_DIV=2): release reset → enable sequence 1110,1101,1011,0111 repeats, each value held 2 cycles. During reset: enable=1111, segments=7'h7F.
- Static "HL" (msg_len=2, mode=00) → digit3=7'h09, digit2=7'h47, digits1,0=7'h7F. wrap stays 0 over 100 ticks.
- Scroll-left "HL" (MSG_LEN=8, STEP_DIV=8, P=6) → the leftmost digit shows H, L, blank×4, H. wrap pulses exactly once, 6 ticks after reset.
- Scroll-right, same setup → the first tick sets offset 5 and wrap=1. The leftmost digit then cycles blank×4, L, H.
- Blink "0" → during the blank phase segments=7'h7F for a full STEP_DIV; otherwise digit3=7'h40. restart asserted on a tick cycle → blank_phase=0 and no toggle.
- Edge cases: msg_len=0 in scroll mode → all blank, no wrap. msg_len=15 with MSG_LEN=8 → behaves as 8. Mode switch mid-scroll → offset 0 on the next cycle.
